// File: rtl/eth_gmii_pkg.sv
// Shared constants, state encoding and CRC bit-step helper for the GMII
// transmit-side sink.
package eth_gmii_pkg;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;
    localparam logic [2:0]  DELAY_DEPTH   = 3'd5;
    localparam logic [2:0]  PRE_CNT_MAX   = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_PAYLOAD  = 2'd2,
        ST_DROP     = 2'd3
    } gmii_state_e;

    // One LSB-first step of the reflected CRC-32 register.
    function automatic logic [31:0] crc32_bit_step(input logic [31:0] crc, input logic din);
        logic [31:0] shifted;
        shifted = {1'b0, crc[31:1]};
        if ((crc[0] ^ din) == 1'b1) begin
            return shifted ^ CRC_POLY;
        end else begin
            return shifted;
        end
    endfunction

endpackage

// File: rtl/eth_crc32_d8.sv
// Combinational CRC-32 update for one data byte, bits consumed LSB first.
module eth_crc32_d8
    import eth_gmii_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    logic [31:0] crc_s;

    // Fold the eight data bits into the CRC register.
    always_comb begin
        crc_s = crc_in;
        for (int i = 32'sd0; i < 32'sd8; i++) begin
            crc_s = crc32_bit_step(crc_s, data[i]);
        end
        crc_out = crc_s;
    end

endmodule

// File: rtl/eth_phy_gmii_sink.sv
// GMII TX deframer: strips preamble/SFD/FCS, checks CRC, length and IFG,
// and streams payload bytes out on a non-back-pressurable AXI-stream port.
module eth_phy_gmii_sink
    import eth_gmii_pkg::*;
#(
    parameter int MIN_FRAME_LENGTH = 64,
    parameter int MAX_FRAME_LENGTH = 1518,
    parameter int MIN_IFG          = 12
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  gmii_txd,
    input  logic        gmii_tx_en,
    input  logic        gmii_tx_er,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tvalid,
    output logic        m_axis_tlast,
    output logic        m_axis_tuser,
    output logic        stat_good,
    output logic        stat_bad_fcs,
    output logic        stat_frame_err,
    output logic        stat_ifg_err,
    output logic [31:0] good_frame_count,
    output logic [31:0] bad_frame_count
);

    localparam logic [15:0] MIN_LEN_C = 16'(MIN_FRAME_LENGTH);
    localparam logic [15:0] MAX_LEN_C = 16'(MAX_FRAME_LENGTH);
    localparam logic [15:0] MAX_SAT_C = 16'(MAX_FRAME_LENGTH + 1);
    localparam logic [7:0]  MIN_IFG_C = 8'(MIN_IFG);

    gmii_state_e state_r, state_s;
    logic [2:0]  pre_cnt_r, pre_cnt_s;
    logic [31:0] crc_r, crc_s, crc_step_s;
    logic [7:0]  dl_r [0:4];
    logic [7:0]  dl_s [0:4];
    logic [2:0]  dl_cnt_r, dl_cnt_s;
    logic [15:0] byte_cnt_r, byte_cnt_s;
    logic        er_seen_r, er_seen_s;
    logic [7:0]  ifg_cnt_r, ifg_cnt_s;
    logic [7:0]  tdata_r, tdata_s;
    logic        tvalid_r, tvalid_s;
    logic        tlast_r, tlast_s;
    logic        tuser_r, tuser_s;
    logic        good_r, good_s;
    logic        bad_fcs_r, bad_fcs_s;
    logic        frame_err_r, frame_err_s;
    logic        ifg_err_r, ifg_err_s;
    logic [31:0] good_cnt_r, good_cnt_s;
    logic [31:0] bad_cnt_r, bad_cnt_s;
    logic        fcs_bad_s, len_bad_s, frame_bad_s;

    eth_crc32_d8 u_crc (
        .crc_in  (crc_r),
        .data    (gmii_txd),
        .crc_out (crc_step_s)
    );

    // Idle-gap counter: counts low-enable cycles, cleared while the MAC transmits.
    always_comb begin
        if (gmii_tx_en) begin
            ifg_cnt_s = 8'd0;
        end else if (ifg_cnt_r == 8'hFF) begin
            ifg_cnt_s = ifg_cnt_r;
        end else begin
            ifg_cnt_s = ifg_cnt_r + 8'd1;
        end
    end

    // Next-state, datapath and output decode for the deframer.
    always_comb begin
        state_s     = state_r;
        pre_cnt_s   = pre_cnt_r;
        crc_s       = crc_r;
        dl_s        = dl_r;
        dl_cnt_s    = dl_cnt_r;
        byte_cnt_s  = byte_cnt_r;
        er_seen_s   = er_seen_r;
        tdata_s     = tdata_r;
        tvalid_s    = 1'b0;
        tlast_s     = 1'b0;
        tuser_s     = 1'b0;
        good_s      = 1'b0;
        bad_fcs_s   = 1'b0;
        frame_err_s = 1'b0;
        ifg_err_s   = 1'b0;
        good_cnt_s  = good_cnt_r;
        bad_cnt_s   = bad_cnt_r;
        fcs_bad_s   = (crc_r != CRC_RESIDUE);
        len_bad_s   = (byte_cnt_r < MIN_LEN_C);
        frame_bad_s = fcs_bad_s | er_seen_r | len_bad_s;

        case (state_r)
            ST_IDLE: begin
                if (gmii_tx_en) begin
                    ifg_err_s = (ifg_cnt_r < MIN_IFG_C);
                    if (gmii_txd == PREAMBLE_BYTE) begin
                        state_s   = ST_PREAMBLE;
                        pre_cnt_s = 3'd1;
                    end else begin
                        state_s     = ST_DROP;
                        frame_err_s = 1'b1;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_PREAMBLE: begin
                if (!gmii_tx_en) begin
                    state_s     = ST_IDLE;
                    frame_err_s = 1'b1;
                end else if (gmii_txd == PREAMBLE_BYTE) begin
                    pre_cnt_s = (pre_cnt_r == PRE_CNT_MAX) ? pre_cnt_r : pre_cnt_r + 3'd1;
                end else if (gmii_txd == SFD_BYTE) begin
                    state_s    = ST_PAYLOAD;
                    crc_s      = CRC_INIT;
                    dl_cnt_s   = 3'd0;
                    byte_cnt_s = 16'd0;
                    er_seen_s  = 1'b0;
                end else begin
                    state_s     = ST_DROP;
                    frame_err_s = 1'b1;
                end
            end

            ST_PAYLOAD: begin
                if (gmii_tx_en) begin
                    crc_s      = crc_step_s;
                    dl_s[0]    = gmii_txd;
                    dl_s[1]    = dl_r[0];
                    dl_s[2]    = dl_r[1];
                    dl_s[3]    = dl_r[2];
                    dl_s[4]    = dl_r[3];
                    dl_cnt_s   = (dl_cnt_r == DELAY_DEPTH) ? dl_cnt_r : dl_cnt_r + 3'd1;
                    byte_cnt_s = (byte_cnt_r == MAX_SAT_C) ? byte_cnt_r : byte_cnt_r + 16'd1;
                    er_seen_s  = er_seen_r | gmii_tx_er;
                    if (dl_cnt_r == DELAY_DEPTH) begin
                        tdata_s  = dl_r[4];
                        tvalid_s = 1'b1;
                    end else begin
                        tvalid_s = 1'b0;
                    end
                    // This byte pushes the frame past the legal maximum: truncate.
                    if (byte_cnt_r >= MAX_LEN_C) begin
                        state_s     = ST_DROP;
                        tlast_s     = 1'b1;
                        tuser_s     = 1'b1;
                        frame_err_s = 1'b1;
                        bad_cnt_s   = bad_cnt_r + 32'd1;
                    end else begin
                        state_s = ST_PAYLOAD;
                    end
                end else begin
                    state_s = ST_IDLE;
                    if (dl_cnt_r == DELAY_DEPTH) begin
                        tdata_s     = dl_r[4];
                        tvalid_s    = 1'b1;
                        tlast_s     = 1'b1;
                        tuser_s     = frame_bad_s;
                        good_s      = ~frame_bad_s;
                        bad_fcs_s   = fcs_bad_s;
                        frame_err_s = er_seen_r | len_bad_s;
                        if (frame_bad_s) begin
                            bad_cnt_s = bad_cnt_r + 32'd1;
                        end else begin
                            good_cnt_s = good_cnt_r + 32'd1;
                        end
                    end else begin
                        // Too short to hold even the FCS: nothing to emit.
                        frame_err_s = 1'b1;
                        bad_cnt_s   = bad_cnt_r + 32'd1;
                    end
                end
            end

            ST_DROP: begin
                if (!gmii_tx_en) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DROP;
                end
            end

            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath, output and statistics registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt_r   <= 3'd0;
            crc_r       <= 32'd0;
            dl_r        <= '{default: 8'h00};
            dl_cnt_r    <= 3'd0;
            byte_cnt_r  <= 16'd0;
            er_seen_r   <= 1'b0;
            ifg_cnt_r   <= 8'hFF;
            tdata_r     <= 8'h00;
            tvalid_r    <= 1'b0;
            tlast_r     <= 1'b0;
            tuser_r     <= 1'b0;
            good_r      <= 1'b0;
            bad_fcs_r   <= 1'b0;
            frame_err_r <= 1'b0;
            ifg_err_r   <= 1'b0;
            good_cnt_r  <= 32'd0;
            bad_cnt_r   <= 32'd0;
        end else begin
            pre_cnt_r   <= pre_cnt_s;
            crc_r       <= crc_s;
            dl_r        <= dl_s;
            dl_cnt_r    <= dl_cnt_s;
            byte_cnt_r  <= byte_cnt_s;
            er_seen_r   <= er_seen_s;
            ifg_cnt_r   <= ifg_cnt_s;
            tdata_r     <= tdata_s;
            tvalid_r    <= tvalid_s;
            tlast_r     <= tlast_s;
            tuser_r     <= tuser_s;
            good_r      <= good_s;
            bad_fcs_r   <= bad_fcs_s;
            frame_err_r <= frame_err_s;
            ifg_err_r   <= ifg_err_s;
            good_cnt_r  <= good_cnt_s;
            bad_cnt_r   <= bad_cnt_s;
        end
    end

    assign m_axis_tdata     = tdata_r;
    assign m_axis_tvalid    = tvalid_r;
    assign m_axis_tlast     = tlast_r;
    assign m_axis_tuser     = tuser_r;
    assign stat_good        = good_r;
    assign stat_bad_fcs     = bad_fcs_r;
    assign stat_frame_err   = frame_err_r;
    assign stat_ifg_err     = ifg_err_r;
    assign good_frame_count = good_cnt_r;
    assign bad_frame_count  = bad_cnt_r;

endmodule

// File: tb/tb_eth_phy_gmii_sink.sv
// Scoreboard bench for eth_phy_gmii_sink: frames are built with their own
// FCS, expected beats are queued when driven and popped as the DUT emits.
module tb_eth_phy_gmii_sink;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  gmii_txd = 8'h00;
    logic        gmii_tx_en = 1'b0;
    logic        gmii_tx_er = 1'b0;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid, m_axis_tlast, m_axis_tuser;
    logic        stat_good, stat_bad_fcs, stat_frame_err, stat_ifg_err;
    logic [31:0] good_frame_count, bad_frame_count;

    eth_phy_gmii_sink #(
        .MIN_FRAME_LENGTH (64),
        .MAX_FRAME_LENGTH (1518),
        .MIN_IFG          (12)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .gmii_txd         (gmii_txd),
        .gmii_tx_en       (gmii_tx_en),
        .gmii_tx_er       (gmii_tx_er),
        .m_axis_tdata     (m_axis_tdata),
        .m_axis_tvalid    (m_axis_tvalid),
        .m_axis_tlast     (m_axis_tlast),
        .m_axis_tuser     (m_axis_tuser),
        .stat_good        (stat_good),
        .stat_bad_fcs     (stat_bad_fcs),
        .stat_frame_err   (stat_frame_err),
        .stat_ifg_err     (stat_ifg_err),
        .good_frame_count (good_frame_count),
        .bad_frame_count  (bad_frame_count)
    );

    always #4 clk = ~clk;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic       user;
    } beat_t;

    beat_t      exp_q[$];
    beat_t      mon_e;
    int         n_checks = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         n_beats = 0, n_last = 0, n_good = 0, n_badfcs = 0, n_ferr = 0, n_ifg = 0;
    int         first_beat_cyc = -1;
    int         drv_cyc = 0;
    logic [7:0] pay [0:1599];

    always @(posedge clk) cyc++;

    // Monitor: pop expected beats and tally status pulses away from the clock edge.
    always @(negedge clk) begin
        if (m_axis_tvalid) begin
            n_beats++;
            if (m_axis_tdata == 8'h00) first_beat_cyc = cyc;
            if (m_axis_tlast) n_last++;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL beat_unexpected: got data %h last %b, required no beat", m_axis_tdata, m_axis_tlast);
            end else begin
                mon_e = exp_q.pop_front();
                if (m_axis_tdata !== mon_e.data || m_axis_tlast !== mon_e.last ||
                    (mon_e.last && m_axis_tuser !== mon_e.user)) begin
                    n_fail++;
                    $display("FAIL beat: got data %h last %b user %b, required data %h last %b user %b",
                             m_axis_tdata, m_axis_tlast, m_axis_tuser, mon_e.data, mon_e.last, mon_e.user);
                end
            end
        end
        if (stat_good) n_good++;
        if (stat_bad_fcs) n_badfcs++;
        if (stat_frame_err) n_ferr++;
        if (stat_ifg_err) n_ifg++;
        if (stat_good || stat_bad_fcs) begin
            n_checks++;
            if (!(m_axis_tvalid && m_axis_tlast)) begin
                n_fail++;
                $display("FAIL pulse_align: stat pulse with tvalid %b tlast %b, required both 1", m_axis_tvalid, m_axis_tlast);
            end
        end
    end

    function automatic logic [31:0] fcs_of(input int len);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < len; i++) begin
            for (int b = 0; b < 8; b++) begin
                if ((c[0] ^ pay[i][b]) == 1'b1) c = (c >> 1) ^ 32'hEDB88320;
                else c = c >> 1;
            end
        end
        return ~c;
    endfunction

    task automatic drive(input logic [7:0] d, input logic en, input logic er);
        @(negedge clk);
        gmii_txd   = d;
        gmii_tx_en = en;
        gmii_tx_er = er;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(8'h00, 1'b0, 1'b0);
    endtask

    task automatic fill(input int len);
        for (int i = 0; i < len; i++) pay[i] = i[7:0];
    endtask

    // Queue expected beats (first n_emit payload bytes) then drive the whole frame.
    task automatic send_frame(input int len, input int n_emit, input logic [7:0] fcs_xor,
                              input int er_idx, input logic exp_user, input int gap);
        logic [31:0] fcs;
        beat_t b;
        fill(len);
        fcs = fcs_of(len);
        for (int i = 0; i < n_emit; i++) begin
            b.data = pay[i];
            b.last = (i == n_emit - 1);
            b.user = exp_user;
            exp_q.push_back(b);
        end
        repeat (7) drive(8'h55, 1'b1, 1'b0);
        drive(8'hD5, 1'b1, 1'b0);
        for (int i = 0; i < len; i++) begin
            drive(pay[i], 1'b1, (i == er_idx));
            if (i == 0) drv_cyc = cyc;
        end
        for (int k = 0; k < 4; k++) drive(fcs[8*k +: 8] ^ ((k == 3) ? fcs_xor : 8'h00), 1'b1, 1'b0);
        idle(gap);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++; if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid: got %b, required 0", m_axis_tvalid); end
        n_checks++; if (m_axis_tlast !== 1'b0) begin n_fail++; $display("FAIL reset_tlast: got %b, required 0", m_axis_tlast); end
        n_checks++; if (stat_frame_err !== 1'b0 || stat_good !== 1'b0) begin n_fail++; $display("FAIL reset_stats: got good %b ferr %b, required 0", stat_good, stat_frame_err); end
        n_checks++; if (good_frame_count !== 32'd0) begin n_fail++; $display("FAIL reset_good_count: got %0d, required 0", good_frame_count); end
        n_checks++; if (bad_frame_count !== 32'd0) begin n_fail++; $display("FAIL reset_bad_count: got %0d, required 0", bad_frame_count); end
        rst_n = 1'b1;
        idle(5);
    endtask

    task automatic test_good_frame();
        int g0 = n_good;
        send_frame(60, 60, 8'h00, -1, 1'b0, 12);
        n_checks++; if (n_good - g0 != 1) begin n_fail++; $display("FAIL good_pulse: got %0d, required 1", n_good - g0); end
        n_checks++; if (good_frame_count !== 32'd1) begin n_fail++; $display("FAIL good_count: got %0d, required 1", good_frame_count); end
        n_checks++; if (first_beat_cyc - drv_cyc != 6) begin n_fail++; $display("FAIL latency: got %0d, required 6", first_beat_cyc - drv_cyc); end
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL good_drain: got %0d left, required 0", exp_q.size()); end
    endtask

    task automatic test_bad_fcs();
        int b0 = n_badfcs;
        int f0 = n_ferr;
        send_frame(60, 60, 8'h01, -1, 1'b1, 12);
        n_checks++; if (n_badfcs - b0 != 1) begin n_fail++; $display("FAIL bad_fcs_pulse: got %0d, required 1", n_badfcs - b0); end
        n_checks++; if (n_ferr != f0) begin n_fail++; $display("FAIL bad_fcs_ferr: got %0d, required 0", n_ferr - f0); end
        n_checks++; if (bad_frame_count !== 32'd1) begin n_fail++; $display("FAIL bad_fcs_count: got %0d, required 1", bad_frame_count); end
    endtask

    task automatic test_tx_er();
        int b0 = n_badfcs;
        int f0 = n_ferr;
        send_frame(60, 60, 8'h00, 10, 1'b1, 12);
        n_checks++; if (n_ferr - f0 != 1) begin n_fail++; $display("FAIL tx_er_ferr: got %0d, required 1", n_ferr - f0); end
        n_checks++; if (n_badfcs != b0) begin n_fail++; $display("FAIL tx_er_fcs: got %0d, required 0", n_badfcs - b0); end
        n_checks++; if (bad_frame_count !== 32'd2) begin n_fail++; $display("FAIL tx_er_count: got %0d, required 2", bad_frame_count); end
    endtask

    task automatic test_runt();
        int f0 = n_ferr;
        int nb;
        send_frame(20, 20, 8'h00, -1, 1'b1, 12);
        n_checks++; if (n_ferr - f0 != 1) begin n_fail++; $display("FAIL short_ferr: got %0d, required 1", n_ferr - f0); end
        n_checks++; if (bad_frame_count !== 32'd3) begin n_fail++; $display("FAIL short_count: got %0d, required 3", bad_frame_count); end
        nb = n_beats;
        repeat (7) drive(8'h55, 1'b1, 1'b0);
        drive(8'hD5, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) drive(8'hA0 + 8'(i), 1'b1, 1'b0);
        idle(12);
        n_checks++; if (n_beats != nb) begin n_fail++; $display("FAIL runt_beats: got %0d, required 0", n_beats - nb); end
        n_checks++; if (n_ferr - f0 != 2) begin n_fail++; $display("FAIL runt_ferr: got %0d, required 1", n_ferr - f0 - 1); end
        n_checks++; if (bad_frame_count !== 32'd4) begin n_fail++; $display("FAIL runt_count: got %0d, required 4", bad_frame_count); end
    endtask

    task automatic test_preamble_abort();
        int f0 = n_ferr;
        int nb = n_beats;
        repeat (3) drive(8'h55, 1'b1, 1'b0);
        idle(12);
        n_checks++; if (n_ferr - f0 != 1) begin n_fail++; $display("FAIL pre_abort_ferr: got %0d, required 1", n_ferr - f0); end
        n_checks++; if (n_beats != nb) begin n_fail++; $display("FAIL pre_abort_beats: got %0d, required 0", n_beats - nb); end
        n_checks++; if (bad_frame_count !== 32'd4) begin n_fail++; $display("FAIL pre_abort_count: got %0d, required 4", bad_frame_count); end
    endtask

    task automatic test_back_to_back();
        n_checks++; if (n_ifg != 0) begin n_fail++; $display("FAIL ifg_early: got %0d, required 0", n_ifg); end
        send_frame(60, 60, 8'h00, -1, 1'b0, 8);
        send_frame(60, 60, 8'h00, -1, 1'b0, 12);
        n_checks++; if (n_ifg != 1) begin n_fail++; $display("FAIL ifg_pulse: got %0d, required 1", n_ifg); end
        n_checks++; if (good_frame_count !== 32'd3) begin n_fail++; $display("FAIL ifg_good_count: got %0d, required 3", good_frame_count); end
    endtask

    task automatic test_truncate();
        int f0 = n_ferr;
        int l0 = n_last;
        send_frame(1515, 1514, 8'h00, -1, 1'b1, 12);
        n_checks++; if (n_ferr - f0 != 1) begin n_fail++; $display("FAIL trunc_ferr: got %0d, required 1", n_ferr - f0); end
        n_checks++; if (n_last - l0 != 1) begin n_fail++; $display("FAIL trunc_last: got %0d, required 1", n_last - l0); end
        n_checks++; if (bad_frame_count !== 32'd5) begin n_fail++; $display("FAIL trunc_count: got %0d, required 5", bad_frame_count); end
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL trunc_drain: got %0d left, required 0", exp_q.size()); end
    endtask

    task automatic test_reset_midframe();
        int f0 = n_ferr;
        int l0 = n_last;
        logic [31:0] fcs;
        beat_t b;
        fill(60);
        fcs = fcs_of(60);
        for (int i = 0; i < 60; i++) begin
            b.data = pay[i];
            b.last = (i == 59);
            b.user = 1'b0;
            exp_q.push_back(b);
        end
        repeat (7) drive(8'h55, 1'b1, 1'b0);
        drive(8'hD5, 1'b1, 1'b0);
        for (int i = 0; i < 30; i++) drive(pay[i], 1'b1, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        gmii_txd = pay[30];
        #1;
        n_checks++; if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_tvalid: got %b, required 0", m_axis_tvalid); end
        exp_q.delete();
        drive(pay[31], 1'b1, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        gmii_txd = pay[32];
        for (int i = 33; i < 60; i++) drive(pay[i], 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) drive(fcs[8*k +: 8], 1'b1, 1'b0);
        idle(12);
        n_checks++; if (n_last != l0) begin n_fail++; $display("FAIL rst_mid_tlast: got %0d, required 0", n_last - l0); end
        n_checks++; if (n_ferr - f0 != 1) begin n_fail++; $display("FAIL rst_mid_ferr: got %0d, required 1", n_ferr - f0); end
        n_checks++; if (bad_frame_count !== 32'd0) begin n_fail++; $display("FAIL rst_mid_bad: got %0d, required 0", bad_frame_count); end
        send_frame(60, 60, 8'h00, -1, 1'b0, 12);
        n_checks++; if (good_frame_count !== 32'd1) begin n_fail++; $display("FAIL rst_mid_good: got %0d, required 1", good_frame_count); end
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rst_mid_drain: got %0d left, required 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_fcs();
        test_tx_er();
        test_runt();
        test_preamble_abort();
        test_back_to_back();
        test_truncate();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
